// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor family: program-store FSM encoding,
// default NOP word and opcode constants used to build programs symbolically.
package proc_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] NOP_DEFAULT = 8'h00;

  localparam logic [3:0] OP_LDI = 4'hF;
  localparam logic [3:0] OP_STA = 4'hD;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_IN  = 4'hC;

  function automatic logic [7:0] instr(input logic [3:0] op, input logic [3:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Simple dual-port program RAM: synchronous write, synchronous read, no reset.
// rd_data holds its value on cycles without a read.
module prog_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/program_store.sv
// Loadable program memory: byte-stream loader (LOAD) then one-cycle-latency fetch
// port (RUN). Fetches at or beyond prog_len return the NOP word and raise fetch_fault.
module program_store
  import proc_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 32,
  parameter logic [7:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_overflow,
  output logic              core_hold,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output state_t            fsm_state
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] NOP_FILL = DATA_W'(NOP_WORD);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W+1)'(DEPTH);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W:0]     wr_cnt;
  logic                beat;
  logic                fetch_fire;
  logic                in_range;
  logic                have_data;
  logic [DATA_W-1:0]   rd_data;

  assign fsm_state  = state;
  assign beat       = load_valid && load_ready;
  assign fetch_fire = fetch_req && (state == ST_RUN);
  assign in_range   = {1'b0, fetch_addr} < prog_len;

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    if (state == ST_LOAD) load_ready = !load_start;
    if (load_start) begin
      state_next = ST_LOAD;
    end else if (beat && (load_last || (wr_cnt == LAST_IDX))) begin
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_LOAD;
      core_hold     <= 1'b1;
      wr_cnt        <= '0;
      prog_len      <= '0;
      load_overflow <= 1'b0;
      fetch_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
      have_data     <= 1'b0;
    end else begin
      state     <= state_next;
      core_hold <= (state == ST_LOAD);
      if (load_start) begin
        wr_cnt        <= '0;
        prog_len      <= '0;
        load_overflow <= 1'b0;
      end else if (beat) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (load_last) begin
          prog_len <= wr_cnt + 1'b1;
        end else if (wr_cnt == LAST_IDX) begin
          prog_len      <= FULL_LEN;
          load_overflow <= 1'b1;
        end
      end
      // A fetch in RUN is served even when load_start arrives in the same cycle.
      fetch_valid <= fetch_fire;
      if (fetch_fire) begin
        fetch_fault <= !in_range;
        have_data   <= 1'b1;
      end
    end
  end

  // RAM output has no reset, so present zero until the first fetch completes.
  assign fetch_data = !have_data ? '0 : (fetch_fault ? NOP_FILL : rd_data);

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (beat),
    .wr_addr (wr_cnt[IDX_W-1:0]),
    .wr_data (load_data),
    .rd_en   (fetch_fire && in_range),
    .rd_addr (fetch_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: load, fetch table, overflow, reload, mid-load reset
// and back-to-back fetch sequences against a small memory model.
module tb_program_store;
  import proc_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              load_overflow;
  logic              core_hold;
  logic [ADDR_W:0]   prog_len;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  state_t            fsm_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] buf_words [64];
  logic [DATA_W-1:0] exp_q [$];
  int                accepted;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_fault;
  } fetch_vec_t;

  fetch_vec_t vecs [6];

  program_store #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_overflow (load_overflow),
    .core_hold     (core_hold),
    .prog_len      (prog_len),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .fetch_fault   (fetch_fault),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, actual, expected);
    end
  endtask

  // drivers
  task automatic load_seq(input int n, input bit with_last);
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = buf_words[i];
      load_last  = with_last && (i == n - 1);
      #0;
      if (load_ready) begin
        if (accepted < DEPTH) model_mem[accepted] = buf_words[i];
        accepted++;
      end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_fetch(input string name, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] exp_data, input logic exp_fault);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    check({name, "_valid"}, 32'(fetch_valid), 32'd1);
    check({name, "_data"},  32'(fetch_data),  32'(exp_data));
    check({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_state"},    32'(fsm_state),     32'(ST_LOAD));
    check({name, "_hold"},     32'(core_hold),     32'd1);
    check({name, "_ready"},    32'(load_ready),    32'd1);
    check({name, "_len"},      32'(prog_len),      32'd0);
    check({name, "_ovf"},      32'(load_overflow), 32'd0);
    check({name, "_fvalid"},   32'(fetch_valid),   32'd0);
    check({name, "_fdata"},    32'(fetch_data),    32'd0);
    check({name, "_ffault"},   32'(fetch_fault),   32'd0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // fetch in LOAD is ignored
    fetch_req = 1'b1;
    fetch_addr = 8'd0;
    tick();
    fetch_req = 1'b0;
    check("load_fetch_ignored", 32'(fetch_valid), 32'd0);

    // five-word program
    buf_words[0] = instr(OP_LDI, 4'h1);
    buf_words[1] = instr(OP_STA, 4'h1);
    buf_words[2] = instr(OP_LDI, 4'h8);
    buf_words[3] = instr(OP_ADD, 4'h1);
    buf_words[4] = instr(OP_STA, 4'h2);
    load_seq(5, 1'b1);
    check("p5_accepted", 32'(accepted), 32'd5);
    check("p5_len", 32'(prog_len), 32'd5);
    check("p5_state", 32'(fsm_state), 32'(ST_RUN));
    check("p5_hold_lag", 32'(core_hold), 32'd1);
    check("p5_ready", 32'(load_ready), 32'd0);
    // fetch issued in the first RUN cycle reads the last written word
    do_fetch("p5_first", 8'd4, 8'hD2, 1'b0);
    check("p5_hold_drop", 32'(core_hold), 32'd0);

    vecs[0] = '{addr: 8'd3,   exp_data: 8'h11, exp_fault: 1'b0};
    vecs[1] = '{addr: 8'd5,   exp_data: 8'h00, exp_fault: 1'b1};
    vecs[2] = '{addr: 8'hFF,  exp_data: 8'h00, exp_fault: 1'b1};
    vecs[3] = '{addr: 8'd0,   exp_data: 8'hF1, exp_fault: 1'b0};
    vecs[4] = '{addr: 8'd2,   exp_data: 8'hF8, exp_fault: 1'b0};
    vecs[5] = '{addr: 8'd128, exp_data: 8'h00, exp_fault: 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault);
    end
    tick();
    check("hold_valid_low", 32'(fetch_valid), 32'd0);
    check("hold_data", 32'(fetch_data), 32'h00);
    check("hold_fault", 32'(fetch_fault), 32'd1);

    // back-to-back fetches on addrs 0,1,2
    for (int i = 0; i < 3; i++) exp_q.push_back(buf_words[i]);
    for (int i = 0; i < 3; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(i);
      tick();
      check($sformatf("b2b%0d_valid", i), 32'(fetch_valid), 32'd1);
      check($sformatf("b2b%0d_data", i), 32'(fetch_data), 32'(exp_q.pop_front()));
    end
    fetch_req = 1'b0;
    tick();
    check("b2b_end_valid", 32'(fetch_valid), 32'd0);

    // overflow: DEPTH+3 beats without load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ovf_start_state", 32'(fsm_state), 32'(ST_LOAD));
    for (int i = 0; i < DEPTH + 3; i++) buf_words[i] = 8'(i * 7 + 3);
    load_seq(DEPTH + 3, 1'b0);
    check("ovf_accepted", 32'(accepted), 32'(DEPTH));
    check("ovf_flag", 32'(load_overflow), 32'd1);
    check("ovf_len", 32'(prog_len), 32'(DEPTH));
    check("ovf_ready", 32'(load_ready), 32'd0);
    tick();
    do_fetch("ovf_last", 8'(DEPTH - 1), model_mem[DEPTH-1], 1'b0);
    do_fetch("ovf_beyond", 8'(DEPTH), 8'h00, 1'b1);

    // load_start in RUN with a beat and a fetch in the same cycle
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    #0;
    check("restart_ready", 32'(load_ready), 32'd0);
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    check("restart_fetch_valid", 32'(fetch_valid), 32'd1);
    check("restart_fetch_data", 32'(fetch_data), 32'(model_mem[1]));
    check("restart_fetch_fault", 32'(fetch_fault), 32'd0);
    check("restart_state", 32'(fsm_state), 32'(ST_LOAD));
    check("restart_len", 32'(prog_len), 32'd0);
    check("restart_ovf", 32'(load_overflow), 32'd0);
    buf_words[0] = instr(OP_IN, 4'h5);
    load_seq(1, 1'b1);
    check("one_len", 32'(prog_len), 32'd1);
    do_fetch("one_addr0", 8'd0, 8'hC5, 1'b0);
    do_fetch("one_addr1", 8'd1, 8'h00, 1'b1);

    // asynchronous reset after 3 of 6 beats
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) buf_words[i] = instr(OP_SUB, 4'(i));
    load_seq(3, 1'b0);
    load_valid = 1'b1;
    load_data  = buf_words[3];
    #2;
    rst = 1'b1;
    #1;
    load_valid = 1'b0;
    check_reset_values("midrst");
    tick();
    rst = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst_nofetch%0d", i), 32'(fetch_valid), 32'd0);
    end
    fetch_req = 1'b0;
    buf_words[0] = instr(OP_CMP, 4'h3);
    buf_words[1] = instr(OP_JMP, 4'h0);
    load_seq(2, 1'b1);
    check("reload_len", 32'(prog_len), 32'd2);
    do_fetch("reload_addr1", 8'd1, 8'hE0, 1'b0);
    do_fetch("reload_addr2", 8'd2, 8'h00, 1'b1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
